// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the Mini-CPU controller: opcodes, FSM states, instruction layout.
// Instruction word: [17:15] opcode, [14:11] dest, [10:7] addr1, [6] sinalImm, [5:0] Imm/addr2.
package mini_cpu_pkg;

  localparam int INSTR_W = 18;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  localparam int OPC_HI  = 17;
  localparam int OPC_LO  = 15;
  localparam int DEST_HI = 14;
  localparam int DEST_LO = 11;
  localparam int A1_HI   = 10;
  localparam int A1_LO   = 7;
  localparam int SIMM_B  = 6;
  localparam int IMM_HI  = 5;
  localparam int IMM_LO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [3:0] dest;
    logic [3:0] addr1;
    logic       sinal_imm;
    logic [5:0] imm;
    logic       is_load;
    logic       is_display;
  } fields_t;

  // Callers size-cast the result down to their data width.
  function automatic int sext_imm(input logic [5:0] imm);
    return int'($signed(imm));
  endfunction

endpackage

// File: rtl/mini_cpu_if.sv
// Controller <-> instruction source / register bank signal bundle.
// master = controller side, slave = source/bank side.
interface mini_cpu_if #(
  parameter int DATA_W = 16
);
  logic [17:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] qF;
  logic [DATA_W-1:0] q1;
  logic [2:0]        opcode;
  logic [3:0]        addr1;
  logic [3:0]        addr2;
  logic [3:0]        dest;
  logic              sinalImm;
  logic [5:0]        Imm;
  logic [DATA_W-1:0] data;
  logic              we;
  logic              done;
  logic [DATA_W-1:0] disp_val;

  modport master (
    input  instr, instr_valid, qF, q1,
    output instr_ready, opcode, addr1, addr2, dest, sinalImm, Imm, data, we, done, disp_val
  );

  modport slave (
    output instr, instr_valid, qF, q1,
    input  instr_ready, opcode, addr1, addr2, dest, sinalImm, Imm, data, we, done, disp_val
  );
endinterface

// File: rtl/mini_cpu_instr_decode.sv
// Combinational split of an instruction word into bank fields plus LOAD/DISPLAY flags.
// LOAD always selects the immediate, so sinal_imm is forced high for it here.
module mini_cpu_instr_decode
  import mini_cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output fields_t            fields
);

  always_comb begin
    fields            = '0;
    fields.opcode     = instr[OPC_HI:OPC_LO];
    fields.dest       = instr[DEST_HI:DEST_LO];
    fields.addr1      = instr[A1_HI:A1_LO];
    fields.imm        = instr[IMM_HI:IMM_LO];
    fields.is_load    = (instr[OPC_HI:OPC_LO] == OP_LOAD);
    fields.is_display = (instr[OPC_HI:OPC_LO] == OP_DISPLAY);
    fields.sinal_imm  = instr[SIMM_B] | fields.is_load;
  end

endmodule

// File: rtl/mini_cpu_ctrl.sv
// Mini-CPU sequencer: IDLE->DECODE->EXEC(EXEC_CYCLES)->WB->DONE, drives register bank ports.
// Optional MINI_CPU_RETIRE_CNT_EN adds a 16-bit retired-instruction counter output.
module mini_cpu_ctrl
  import mini_cpu_pkg::*;
#(
  parameter int EXEC_CYCLES = 2,
  parameter int DATA_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  mini_cpu_if.master bus
`ifdef MINI_CPU_RETIRE_CNT_EN
  ,
  output logic [15:0] retired_cnt
`endif
);

  state_t            state;
  state_t            state_nxt;
  fields_t           dec;
  fields_t           cur;
  logic [3:0]        exec_cnt;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] disp_q;
  logic              accept;
  logic              exec_last;

  mini_cpu_instr_decode u_decode (
    .instr  (bus.instr),
    .fields (dec)
  );

  assign accept    = bus.instr_valid && bus.instr_ready;
  assign exec_last = (state == ST_EXEC) && (exec_cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   if (exec_cnt == 4'd0) state_nxt = ST_WB;
      ST_WB:     state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= '0;
      exec_cnt <= '0;
      data_q   <= '0;
      disp_q   <= '0;
    end else begin
      if (accept) cur <= dec;
      if (state == ST_DECODE)    exec_cnt <= 4'(EXEC_CYCLES - 1);
      else if (state == ST_EXEC) exec_cnt <= exec_cnt - 4'd1;
      // qF is taken on the edge leaving EXEC, so dest==addr reads the pre-write value.
      if (exec_last) data_q <= cur.is_load ? DATA_W'(sext_imm(cur.imm)) : bus.qF;
      if (state == ST_WB && cur.is_display) disp_q <= bus.q1;
    end
  end

  // Strobes decode straight from state so an async reset kills them in the same cycle.
  assign bus.instr_ready = (state == ST_IDLE) && !rst;
  assign bus.we          = (state == ST_WB) && !cur.is_display;
  assign bus.done        = (state == ST_DONE);
  assign bus.opcode      = cur.opcode;
  assign bus.addr1       = cur.addr1;
  assign bus.addr2       = cur.imm[5:2];
  assign bus.dest        = cur.dest;
  assign bus.sinalImm    = cur.sinal_imm;
  assign bus.Imm         = cur.imm;
  assign bus.data        = data_q;
  assign bus.disp_val    = disp_q;

`ifdef MINI_CPU_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 retired_cnt <= '0;
    else if (state == ST_DONE) retired_cnt <= retired_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mini_cpu_ctrl.sv
// Randomized bench for mini_cpu_ctrl against a per-instruction timing/data reference model.
module tb_mini_cpu_ctrl;
  import mini_cpu_pkg::*;

  localparam int E      = 2;
  localparam int DW     = 16;
  localparam int NSTEPS = 4 + E;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  logic [DW-1:0] exp_disp = '0;

  mini_cpu_if #(.DATA_W(DW)) bus ();

`ifdef MINI_CPU_RETIRE_CNT_EN
  logic [15:0] retired_cnt;
`endif

  mini_cpu_ctrl #(.EXEC_CYCLES(E), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MINI_CPU_RETIRE_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One instruction, observed after every edge from acceptance (j=0) back to IDLE.
  task automatic run_instr(input logic [17:0] ins, input bit hold);
    logic [DW-1:0] qh  [0:NSTEPS];
    logic [DW-1:0] q1h [0:NSTEPS];
    logic [2:0]    op;
    logic [5:0]    imm;
    bit            disp;
    int            waited;
    logic [DW-1:0] exp_data;
    op     = ins[17:15];
    imm    = ins[5:0];
    disp   = (op == 3'b111);
    waited = 0;
    while (!bus.instr_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.instr_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    bus.qF          = DW'($urandom);
    bus.q1          = DW'($urandom);
    qh[0]  = bus.qF;
    q1h[0] = bus.q1;
    for (int j = 0; j <= 3 + E; j++) begin
      @(negedge clk);
      check("ready", 32'(bus.instr_ready), 32'(j == 3 + E));
      check("we",    32'(bus.we),          32'(j == 1 + E && !disp));
      check("done",  32'(bus.done),        32'(j == 2 + E));
      if (j >= 1 && j <= 2 + E) begin
        check("opcode",   32'(bus.opcode),   32'(op));
        check("dest",     32'(bus.dest),     32'(ins[14:11]));
        check("addr1",    32'(bus.addr1),    32'(ins[10:7]));
        check("addr2",    32'(bus.addr2),    32'(imm[5:2]));
        check("imm",      32'(bus.Imm),      32'(imm));
        check("sinalimm", 32'(bus.sinalImm), 32'(op == 3'b000 ? 1'b1 : ins[6]));
      end
      if (j == 1 + E && !disp) begin
        exp_data = (op == 3'b000) ? DW'(int'($signed(imm))) : qh[1 + E];
        check("data", 32'(bus.data), 32'(exp_data));
      end
      if (j == 2 + E) begin
        if (disp) exp_disp = q1h[2 + E];
        n_done++;
        check("disp_val", 32'(bus.disp_val), 32'(exp_disp));
      end
      if (j == 0) begin
        if (hold) bus.instr = 18'($urandom);
        else      bus.instr_valid = 1'b0;
      end
      bus.qF     = DW'($urandom);
      bus.q1     = DW'($urandom);
      qh[j + 1]  = bus.qF;
      q1h[j + 1] = bus.q1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(bus.we),       32'd0);
    check({tag, "_done"},  32'(bus.done),     32'd0);
    check({tag, "_ready"}, 32'(bus.instr_ready), 32'd0);
    check({tag, "_disp"},  32'(bus.disp_val), 32'd0);
    check({tag, "_data"},  32'(bus.data),     32'd0);
  endtask

  initial begin
    logic [17:0] ins;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.qF          = '0;
    bus.q1          = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.instr_ready), 32'd1);

    // Directed: LOAD -1 into r3, ADD into r5, DISPLAY r2.
    run_instr({3'b000, 4'd3, 4'd0, 1'b0, 6'h3F}, 1'b0);
    run_instr({3'b001, 4'd5, 4'd1, 1'b0, 6'h08}, 1'b0);
    run_instr({3'b111, 4'd0, 4'd2, 1'b0, 6'h00}, 1'b0);
    // Three back-to-back with valid held high (garbage instr while busy).
    run_instr({3'b010, 4'd7, 4'd7, 1'b1, 6'h15}, 1'b1);
    run_instr({3'b000, 4'd9, 4'd1, 1'b0, 6'h05}, 1'b1);
    run_instr({3'b110, 4'd2, 4'd3, 1'b0, 6'h2C}, 1'b0);

    // Reset mid-EXEC: no write may follow.
    bus.instr       = {3'b011, 4'd4, 4'd4, 1'b0, 6'h10};
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_exec");
    exp_disp = '0;
    n_done   = 0;
    repeat (4) begin
      @(negedge clk);
      check("rst_exec_nowe", 32'(bus.we), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst2", 32'(bus.instr_ready), 32'd1);
    check("we_after_rst2",    32'(bus.we),          32'd0);

    // Reset while we is high: we must fall without waiting for an edge.
    bus.instr       = {3'b100, 4'd6, 4'd1, 1'b0, 6'h04};
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    repeat (E + 1) @(negedge clk);
    check("we_before_rst3", 32'(bus.we), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_wb_we", 32'(bus.we), 32'd0);
    check("rst_wb_done", 32'(bus.done), 32'd0);
    n_done = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      ins = 18'($urandom);
      if (k % 5 == 0) ins[17:15] = 3'b111;
      if (k % 7 == 0) ins[17:15] = 3'b000;
      run_instr(ins, 1'($urandom_range(0, 1)));
      bus.instr_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef MINI_CPU_RETIRE_CNT_EN
    check("retired_cnt", 32'(retired_cnt), 32'(n_done[15:0]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
